// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-operation and FSM-state definitions for the fetch/decode
// controller and its instruction decoder.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_ADDI = 4'h4,
    OP_ANDI = 4'h5,
    OP_ORI  = 4'h6,
    OP_BEQZ = 4'h8,
    OP_JMP  = 4'h9,
    OP_HALT = 4'hF
  } opcode_e;

  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_e;

  // Everything the controller needs to know about the instruction register.
  typedef struct packed {
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic [7:0] imm;
    logic       alu_src;
    logic [1:0] alu_ctrl;
    logic       reg_write;
    logic       is_beqz;
    logic       is_jmp;
    logic       is_halt;
    logic       illegal;
  } dec_t;

  // Opcodes that write the register file also refresh the zero flag.
  function automatic logic is_reg_write(input logic [3:0] op);
    return op inside {OP_ADD, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational field extraction and opcode-to-control mapping for
// the 16-bit instruction format.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int IW = 16
) (
  input  logic [IW-1:0] ir_i,
  output dec_t          dec_o
);

  logic [3:0] op;

  assign op = ir_i[15:12];

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // bit unassigned; otherwise synthesis infers a latch.
    dec_o           = '0;
    dec_o.rd        = ir_i[11:8];
    dec_o.rs1       = ir_i[7:4];
    dec_o.rs2       = ir_i[3:0];
    dec_o.imm       = ir_i[7:0];
    dec_o.reg_write = is_reg_write(op);
    dec_o.alu_src   = op inside {OP_ADDI, OP_ANDI, OP_ORI};

    case (op)
      OP_NOP:           ;
      OP_ADD,  OP_ADDI: dec_o.alu_ctrl = ALU_ADD;
      OP_AND,  OP_ANDI: dec_o.alu_ctrl = ALU_AND;
      OP_OR,   OP_ORI:  dec_o.alu_ctrl = ALU_OR;
      OP_BEQZ:          dec_o.is_beqz  = 1'b1;
      OP_JMP:           dec_o.is_jmp   = 1'b1;
      OP_HALT:          dec_o.is_halt  = 1'b1;
      default:          dec_o.illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode controller: four cycles per instruction
// (FETCH, DECODE, EXECUTE, WRITEBACK) driving a register-file/ALU stage.
module fetch_decode_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int IW   = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            run,
  output logic [PC_W-1:0] instr_addr,
  input  logic [IW-1:0]   instr_data,
  input  logic            Zero,
  output logic [3:0]      RA1,
  output logic [3:0]      RA2,
  output logic [3:0]      WA,
  output logic [7:0]      immediate,
  output logic            write_enable,
  output logic            ALUsrc,
  output logic [1:0]      ALUControl,
  output logic            halted,
  output logic            illegal_op
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q,    pc_d;
  logic [IW-1:0]   ir_q,    ir_d;
  logic            z_q,     z_d;
  dec_t            dec;
  logic            exec_win;
  logic            branch_taken;

  instr_decoder #(.IW(IW)) u_dec (
    .ir_i  (ir_q),
    .dec_o (dec)
  );

  assign branch_taken = (dec.is_beqz && z_q) || dec.is_jmp;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    z_d     = z_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        // The ROM word addressed in FETCH is valid by the end of DECODE.
        state_d = S_EXECUTE;
        ir_d    = instr_data;
      end
      S_EXECUTE: begin
        state_d = dec.is_halt ? S_HALT : S_WRITEBACK;
        if (dec.reg_write) z_d = Zero;
      end
      S_WRITEBACK: begin
        state_d = S_FETCH;
        pc_d    = branch_taken ? PC_W'(dec.imm) : pc_q + PC_W'(1);
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples the pre-edge value of its neighbours.
    if (RST) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
    end
  end

  // Operand fields are decoded only from registered state, so they stay
  // constant across the whole EXECUTE/WRITEBACK window.
  assign exec_win = (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);

  always_comb begin
    RA1        = '0;
    RA2        = '0;
    WA         = '0;
    immediate  = '0;
    ALUsrc     = 1'b0;
    ALUControl = ALU_AND;
    if (exec_win) begin
      RA1        = dec.rs1;
      RA2        = dec.rs2;
      WA         = dec.rd;
      immediate  = dec.imm;
      ALUsrc     = dec.alu_src;
      ALUControl = dec.alu_ctrl;
    end
  end

  // The register file writes on the same edge that samples RST, so the
  // strobe must be masked combinationally to abort an in-flight write.
  assign write_enable = (state_q == S_WRITEBACK) && dec.reg_write && !RST;
  assign illegal_op   = (state_q == S_EXECUTE) && dec.illegal;
  assign halted       = (state_q == S_HALT);
  assign instr_addr   = pc_q;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Self-checking bench: an instruction-level reference model walks the ROM
// program and predicts every output for each of the four instruction cycles.
module tb_fetch_decode_ctrl;

  localparam int PC_W = 8;
  localparam int IW   = 16;

  logic            CLK = 1'b0;
  logic            RST;
  logic            run;
  logic [PC_W-1:0] instr_addr;
  logic [IW-1:0]   instr_data;
  logic            Zero;
  logic [3:0]      RA1, RA2, WA;
  logic [7:0]      immediate;
  logic            write_enable, ALUsrc;
  logic [1:0]      ALUControl;
  logic            halted, illegal_op;

  fetch_decode_ctrl #(.PC_W(PC_W), .IW(IW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .run          (run),
    .instr_addr   (instr_addr),
    .instr_data   (instr_data),
    .Zero         (Zero),
    .RA1          (RA1),
    .RA2          (RA2),
    .WA           (WA),
    .immediate    (immediate),
    .write_enable (write_enable),
    .ALUsrc       (ALUsrc),
    .ALUControl   (ALUControl),
    .halted       (halted),
    .illegal_op   (illegal_op)
  );

  always #5 CLK = ~CLK;

  // Synchronous program ROM, one cycle of read latency.
  logic [15:0] rom [256];
  always @(posedge CLK) instr_data <= rom[instr_addr];

  int n_checks = 0;
  int n_errors = 0;

  // ISA-level model state and per-opcode property tables.
  logic [7:0] m_pc;
  logic       m_z;
  logic [1:0] alu_tbl [16];
  logic       src_tbl [16];
  logic       wr_tbl  [16];
  logic       ill_tbl [16];

  function automatic logic [25:0] observed();
    return {RA1, RA2, WA, immediate, ALUsrc, ALUControl, write_enable, illegal_op, halted};
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  task automatic init_tables();
    for (int o = 0; o < 16; o++) begin
      alu_tbl[o] = 2'b00;
      src_tbl[o] = 1'b0;
      wr_tbl[o]  = 1'b0;
      ill_tbl[o] = 1'b0;
    end
    alu_tbl[1] = 2'b10; alu_tbl[4] = 2'b10;
    alu_tbl[3] = 2'b01; alu_tbl[6] = 2'b01;
    for (int o = 4; o <= 6; o++) src_tbl[o] = 1'b1;
    for (int o = 1; o <= 6; o++) wr_tbl[o] = 1'b1;
    ill_tbl[7] = 1'b1;
    for (int o = 10; o <= 14; o++) ill_tbl[o] = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    run = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Called at a negedge while IDLE; returns at the negedge inside FETCH.
  task automatic start_run();
    run = 1'b1;
    m_pc = 8'h00;
    m_z  = 1'b0;
    @(negedge CLK);
  endtask

  // Runs one instruction, entered and left at the negedge inside FETCH.
  task automatic step_instr(input logic zin, output logic did_halt);
    logic [15:0] ins;
    logic [3:0]  op;
    logic [25:0] exp_v;
    ins      = rom[m_pc];
    op       = ins[15:12];
    did_halt = 1'b0;
    Zero     = zin;
    run      = 1'($urandom_range(0, 1));

    n_checks++;
    if (instr_addr !== m_pc) begin
      n_errors++;
      $display("FAIL fetch_addr got=%02h exp=%02h", instr_addr, m_pc);
    end
    n_checks++;
    if (observed() !== 26'd0) begin
      n_errors++;
      $display("FAIL fetch_idle_outputs pc=%02h got=%07h exp=0000000", m_pc, observed());
    end

    @(negedge CLK);
    n_checks++;
    if (observed() !== 26'd0 || instr_addr !== m_pc) begin
      n_errors++;
      $display("FAIL decode_outputs pc=%02h got=%07h/%02h exp=0000000/%02h",
               m_pc, observed(), instr_addr, m_pc);
    end

    @(negedge CLK);
    exp_v = {ins[7:4], ins[3:0], ins[11:8], ins[7:0], src_tbl[op], alu_tbl[op],
             1'b0, ill_tbl[op], 1'b0};
    n_checks++;
    if (observed() !== exp_v) begin
      n_errors++;
      $display("FAIL execute_ctrl pc=%02h ins=%04h got=%07h exp=%07h", m_pc, ins, observed(), exp_v);
    end

    if (op == 4'hF) begin
      did_halt = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(negedge CLK);
        run  = 1'($urandom_range(0, 1));
        Zero = 1'($urandom_range(0, 1));
        n_checks++;
        if (observed() !== 26'd1 || instr_addr !== m_pc) begin
          n_errors++;
          $display("FAIL halt_hold cyc=%0d got=%07h/%02h exp=0000001/%02h",
                   c, observed(), instr_addr, m_pc);
        end
      end
      return;
    end

    @(negedge CLK);
    exp_v = {ins[7:4], ins[3:0], ins[11:8], ins[7:0], src_tbl[op], alu_tbl[op],
             wr_tbl[op], 1'b0, 1'b0};
    n_checks++;
    if (observed() !== exp_v) begin
      n_errors++;
      $display("FAIL writeback_ctrl pc=%02h ins=%04h got=%07h exp=%07h", m_pc, ins, observed(), exp_v);
    end

    if (wr_tbl[op]) m_z = zin;
    if ((op == 4'h8 && m_z) || op == 4'h9) m_pc = ins[7:0];
    else                                    m_pc = m_pc + 8'd1;

    @(negedge CLK);
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST  = 1'b1;
    run  = 1'b1;
    Zero = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    n_checks++;
    if (observed() !== 26'd0 || instr_addr !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_outputs got=%07h/%02h exp=0000000/00", observed(), instr_addr);
    end
    RST = 1'b0;
    run = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_checks++;
      if (observed() !== 26'd0 || instr_addr !== 8'h00) begin
        n_errors++;
        $display("FAIL idle_hold cyc=%0d got=%07h/%02h exp=0000000/00", c, observed(), instr_addr);
      end
    end
  endtask

  // ADDI, ADD, taken/untaken BEQZ, JMP to 0xFF with wrap, illegal op, HALT.
  task automatic test_program();
    int   zsel [14] = '{0, 0, 1, 2, 0, 2, 2, 2, 0, 0, 0, 2, 2, 2};
    logic h;
    for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
    rom[8'h00] = 16'h4111;
    rom[8'h01] = 16'h1312;
    rom[8'h02] = 16'h2345;
    rom[8'h03] = 16'h8040;
    rom[8'h04] = 16'h7123;
    rom[8'h05] = 16'hF000;
    rom[8'h40] = 16'h2000;
    rom[8'h41] = 16'h8050;
    rom[8'h42] = 16'h90FF;
    rom[8'hFF] = 16'h0000;
    do_reset();
    start_run();
    for (int s = 0; s < 14; s++) begin
      step_instr((zsel[s] == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel[s]), h);
      if (h) break;
    end
  endtask

  task automatic test_reset_in_writeback();
    logic h;
    rom[8'h00] = 16'h4111;
    rom[8'h01] = 16'h1312;
    do_reset();
    start_run();
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    n_checks++;
    if (write_enable !== 1'b1) begin
      n_errors++;
      $display("FAIL wb_before_reset write_enable got=%b exp=1", write_enable);
    end
    RST = 1'b1;
    #1;
    n_checks++;
    if (write_enable !== 1'b0) begin
      n_errors++;
      $display("FAIL wb_reset_abort write_enable got=%b exp=0", write_enable);
    end
    @(negedge CLK);
    n_checks++;
    if (observed() !== 26'd0 || instr_addr !== 8'h00) begin
      n_errors++;
      $display("FAIL wb_reset_state got=%07h/%02h exp=0000000/00", observed(), instr_addr);
    end
    RST = 1'b0;
    run = 1'b0;
    repeat (3) @(negedge CLK);
    start_run();
    for (int s = 0; s < 2; s++) step_instr(1'($urandom_range(0, 1)), h);
  endtask

  task automatic test_random();
    logic        h;
    logic [15:0] w;
    for (int a = 0; a < 256; a++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'h0;
      rom[a] = w;
    end
    do_reset();
    start_run();
    for (int s = 0; s < 60; s++) step_instr(1'($urandom_range(0, 1)), h);
    rom[m_pc] = 16'hF0AB;
    step_instr(1'($urandom_range(0, 1)), h);
  endtask

  initial begin
    RST  = 1'b1;
    run  = 1'b0;
    Zero = 1'b0;
    init_tables();
    test_reset();
    test_program();
    test_reset_in_writeback();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
